// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: one-command-at-a-time burst controller in front of a 64 KiB byte memory.
// Define MEMCTRL_RANGE_ERR_EN to reject bursts running past 0xFFFF; otherwise the address wraps.
module mem_burst_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             err,
    output logic [7:0]       mem_msb_addr,
    output logic [7:0]       mem_lsb_addr,
    output logic [7:0]       mem_wval,
    output logic             mem_wen,
    input  logic [7:0]       mem_rval
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    localparam logic [LEN_W:0] ONE = 1;
    state_t         state;
    logic [15:0]    addr;
    logic [LEN_W:0] left;
    logic [7:0]     f0, f1;
    logic [1:0]     count;
    logic           inflight, pop, issue, beat, range_bad;
    assign cmd_ready    = state == IDLE;
    assign busy         = !cmd_ready;
    assign wr_ready     = state == WRITE;
    assign beat         = wr_ready & wr_valid;
    assign mem_wen      = beat & !rst;
    assign mem_wval     = wr_ready ? wr_data : 8'h00;
    assign mem_msb_addr = addr[15:8];
    assign mem_lsb_addr = addr[7:0];
    assign rd_valid     = count != 2'd0;
    assign rd_data      = rd_valid ? f0 : 8'h00;
    assign pop          = rd_valid & rd_ready;
    // Issue only if the byte it returns is guaranteed a FIFO slot.
    assign issue = state == READ && left != '0 &&
                   ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
`ifdef MEMCTRL_RANGE_ERR_EN
    assign range_bad = ({1'b0, cmd_addr} + 17'(cmd_len)) > 17'h0FFFF;
    always_ff @(posedge clk)
        err <= rst ? 1'b0 : cmd_valid & cmd_ready & range_bad;
`else
    assign range_bad = 1'b0;
    assign err       = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            left     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            f0       <= '0;
            f1       <= '0;
        end else begin
            inflight <= issue;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (pop)
                f0 <= f1;
            if (inflight) begin
                if ((count - {1'b0, pop}) == 2'd0)
                    f0 <= mem_rval;
                else
                    f1 <= mem_rval;
            end
            case (state)
                IDLE: if (cmd_valid) begin
                    addr <= cmd_addr;
                    left <= {1'b0, cmd_len} + ONE;
                    if (!range_bad)
                        state <= cmd_write ? WRITE : READ;
                end
                WRITE: if (beat) begin
                    addr <= addr + 16'd1;
                    left <= left - ONE;
                    if (left == ONE)
                        state <= IDLE;
                end
                READ: begin
                    if (issue) begin
                        addr <= addr + 16'd1;
                        left <= left - ONE;
                    end
                    if (left == '0 && count == 2'd0 && !inflight)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bursts against a bench memory, with a scoreboard of expected
// memory writes and read bytes checked every cycle plus literal spot checks.
module tb_mem_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [15:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [7:0]  wr_data = 0;
    logic        rd_valid, rd_ready = 0;
    logic [7:0]  rd_data;
    logic        busy, err;
    logic [7:0]  mem_msb_addr, mem_lsb_addr, mem_wval, mem_rval;
    logic        mem_wen;

    int tests = 0;
    int fails = 0;
    logic [7:0]  mem [65536];
    logic [7:0]  ref_mem [65536];
    logic [23:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [7:0]  wbuf [$];
    logic        hold = 0, prev_rst = 1;
    logic [7:0]  hold_data = 0;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .err(err), .mem_msb_addr(mem_msb_addr), .mem_lsb_addr(mem_lsb_addr),
        .mem_wval(mem_wval), .mem_wen(mem_wen), .mem_rval(mem_rval)
    );

    // Bench memory: write on the accepting edge, registered read data one cycle later.
    always @(posedge clk) begin
        if (mem_wen)
            mem[{mem_msb_addr, mem_lsb_addr}] <= mem_wval;
        mem_rval <= mem[{mem_msb_addr, mem_lsb_addr}];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every memory write and every consumed read byte must match the expected stream.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_vs_ready", busy, !cmd_ready);
            if (mem_wen) begin
                if (exp_wr.size() == 0)
                    check("unexpected_write", 1, 0);
                else begin
                    logic [23:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", {mem_msb_addr, mem_lsb_addr}, e[23:8]);
                    check("wr_data", mem_wval, e[7:0]);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0)
                    check("unexpected_read", 1, 0);
                else
                    check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (hold && !prev_rst) begin
                check("rd_hold_valid", rd_valid, 1);
                check("rd_hold_data", rd_data, hold_data);
            end
        end
        hold      = rd_valid && !rd_ready && !rst;
        hold_data = rd_data;
        prev_rst  = rst;
    end

    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready)
            check("cmd_ready_timeout", 0, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    // Sends wbuf as a write burst; gap[i % glen] gives wr_valid per cycle.
    task automatic write_burst(input logic [15:0] a, input logic [7:0] gap, input int glen);
        int k = 0;
        int i = 0;
        send_cmd(1, a, 8'(wbuf.size() - 1));
        while (k < wbuf.size()) begin
            wr_valid = gap[i % glen];
            wr_data  = wbuf[k];
            if (wr_valid) begin
                exp_wr.push_back({16'(a + k), wbuf[k]});
                ref_mem[16'(a + k)] = wbuf[k];
                k++;
            end
            @(posedge clk); #1;
            i++;
        end
        wr_valid = 0;
    endtask

    task automatic drain(input logic [3:0] pat, input int plen);
        int n = 0;
        while (exp_rd.size() > 0 && n < 300) begin
            rd_ready = pat[n % plen];
            @(posedge clk); #1;
            n++;
        end
        if (exp_rd.size() > 0)
            check("read_drain_timeout", exp_rd.size(), 0);
        rd_ready = 0;
    endtask

    task automatic expect_read(input logic [15:0] a, input logic [7:0] l);
        for (int i = 0; i <= int'(l); i++)
            exp_rd.push_back(ref_mem[16'(a + i)]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_wval", mem_wval, 8'h00);
        check("rst_addr", {mem_msb_addr, mem_lsb_addr}, 16'h0000);

        // Beats with no burst active must not reach memory.
        @(posedge clk); #1 wr_valid = 1; wr_data = 8'hEE;
        @(negedge clk);
        check("idle_wr_ready", wr_ready, 0);
        check("idle_mem_wen", mem_wen, 0);
        @(posedge clk); #1 wr_valid = 0;

        // 4-beat write across a page boundary.
        wbuf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        write_burst(16'h12FE, 4'b1111, 4);
        @(negedge clk);
        check("wr1_idle", cmd_ready, 1);
        check("wr1_mem0", mem[16'h12FE], 8'hA0);
        check("wr1_mem3", mem[16'h1301], 8'hA3);

        // Read back with rd_ready held: rd_valid rises two edges after acceptance.
        expect_read(16'h12FE, 3);
        rd_ready = 1;
        send_cmd(0, 16'h12FE, 3);
        @(negedge clk);
        check("rd1_first_addr", {mem_msb_addr, mem_lsb_addr}, 16'h12FE);
        check("rd1_valid_e1", rd_valid, 0);
        @(negedge clk);
        check("rd1_valid_e2", rd_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rd1_stream_valid", rd_valid, 1);
            check("rd1_stream_data", rd_data, 8'hA0 + 8'(i));
        end
        drain(4'b1111, 4);

        // Write with wr_valid gaps 1,0,1,1.
        wbuf = '{8'h11, 8'h22, 8'h33};
        write_burst(16'h2000, 4'b1101, 4);
        @(posedge clk); #1;
        check("gap_mem1", mem[16'h2001], 8'h22);
        check("gap_mem2", mem[16'h2002], 8'h33);

        // 6-beat read under backpressure: two buffered, issue stalls, then toggled rd_ready.
        wbuf = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        write_burst(16'h3000, 4'b1111, 4);
        expect_read(16'h3000, 5);
        send_cmd(0, 16'h3000, 5);
        repeat (5) begin @(posedge clk); #1; end
        check("bp_addr_stalled", {mem_msb_addr, mem_lsb_addr}, 16'h3002);
        check("bp_rd_valid", rd_valid, 1);
        check("bp_rd_head", rd_data, 8'h30);
        drain(4'b1001, 4);
        check("bp_queue_empty", exp_rd.size(), 0);

        // Reset during the second beat of a 5-beat read.
        send_cmd(0, 16'h4000, 4);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_mem_wen", mem_wen, 0);
        check("mid_rst_busy", busy, 0);

`ifdef MEMCTRL_RANGE_ERR_EN
        send_cmd(1, 16'hFFFF, 1);
        @(negedge clk);
        check("range_err_pulse", err, 1);
        check("range_stays_idle", cmd_ready, 1);
        @(negedge clk);
        check("range_err_one_cycle", err, 0);
`else
        wbuf = '{8'h5A, 8'h5B};
        write_burst(16'hFFFF, 4'b1111, 4);
        @(negedge clk);
        check("wrap_err_zero", err, 0);
        check("wrap_mem_ffff", mem[16'hFFFF], 8'h5A);
        check("wrap_mem_0000", mem[16'h0000], 8'h5B);
        expect_read(16'hFFFF, 1);
        send_cmd(0, 16'hFFFF, 1);
        drain(4'b1111, 4);
`endif
        repeat (4) @(posedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
